// File: rtl/shift_reg_sequencer_if.sv
// shift_reg_sequencer_if: command channel between a requester and the shift register sequencer
interface shift_reg_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_data;
    logic [CNT_W-1:0] cmd_count;
    logic             cmd_dir;
    logic             cmd_rotate;
    logic             cmd_fill;
    modport master (
        output cmd_valid, cmd_data, cmd_count, cmd_dir, cmd_rotate, cmd_fill,
        input  cmd_ready
    );
    modport slave (
        input  cmd_valid, cmd_data, cmd_count, cmd_dir, cmd_rotate, cmd_fill,
        output cmd_ready
    );
endinterface

// File: rtl/shift_reg_sequencer.sv
// shift_reg_sequencer: loads a word into a universal shift register, shifts it N times, returns the result
module shift_reg_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    shift_reg_sequencer_if.slave cmd,
    input  logic                 abort_i,
    input  logic [WIDTH-1:0]     sr_q_i,
    output logic                 sr_s1_o,
    output logic                 sr_s0_o,
    output logic [WIDTH-1:0]     sr_p_in_o,
    output logic                 sr_sl_in_o,
    output logic                 sr_sr_in_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [WIDTH-1:0]     result_o
);
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
    state_t           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [WIDTH-1:0] data_q, result_q;
    logic [CNT_W-1:0] count_q;
    logic             dir_q, rotate_q, fill_q, done_q, accept, finish;
    assign cmd.cmd_ready = (state_q == IDLE) && !rst;
    assign busy_o        = (state_q != IDLE);
    assign done_o        = done_q;
    assign result_o      = result_q;
    assign sr_p_in_o     = data_q;
    assign {sr_s1_o, sr_s0_o} = mode_q;
    // rotation feeds the register's far end back in; otherwise the latched fill bit enters
    always_comb begin
        sr_sr_in_o = rst ? 1'b0 : rotate_q ? sr_q_i[0] : fill_q;
        sr_sl_in_o = rst ? 1'b0 : rotate_q ? sr_q_i[WIDTH-1] : fill_q;
    end
    // next state: abort wins in any active state, the count picks SHIFT length, mode follows the state entered
    always_comb begin
        accept  = cmd.cmd_valid && cmd.cmd_ready && !abort_i;
        finish  = (state_q == DONE) && !abort_i;
        state_d = (state_q == IDLE)  ? (accept ? LOAD : IDLE) :
                  abort_i            ? IDLE :
                  (state_q == LOAD)  ? ((count_q == '0) ? DONE : SHIFT) :
                  (state_q == SHIFT) ? ((count_q == CNT_W'(1)) ? DONE : SHIFT) : IDLE;
        mode_d  = (state_d == LOAD)  ? 2'b11 :
                  (state_d == SHIFT) ? (dir_q ? 2'b10 : 2'b01) : 2'b00;
    end
    // controller state, latched command fields, shift counter and registered result/done
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            mode_q   <= 2'b00;
            data_q   <= '0;
            result_q <= '0;
            count_q  <= '0;
            dir_q    <= 1'b0;
            rotate_q <= 1'b0;
            fill_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            done_q  <= finish;
            if (finish) result_q <= sr_q_i;
            if (accept) begin
                data_q   <= cmd.cmd_data;
                count_q  <= cmd.cmd_count;
                dir_q    <= cmd.cmd_dir;
                rotate_q <= cmd.cmd_rotate;
                fill_q   <= cmd.cmd_fill;
            end else if (state_q == SHIFT && !abort_i) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end
endmodule
